// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and request record for the register-file writeback arbiter.
package regfile_pkg;
  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int NREGS    = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus, reservation port and register-file write port bundle.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_dst;
  logic [NREQ*DW-1:0] req_data;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_reg;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [2**AW-1:0]   busy;
  logic               rsv_conflict;

  modport slave (
    input  req_valid, req_dst, req_data, rsv_valid, rsv_reg,
    output req_ready, rf_we, rf_waddr, rf_wdata, busy, rsv_conflict
  );

  modport master (
    output req_valid, req_dst, req_data, rsv_valid, rsv_reg,
    input  req_ready, rf_we, rf_waddr, rf_wdata, busy, rsv_conflict
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// One-hot grant arbiter; round-robin after i_ptr by default, lowest-index-wins
// when REGFILE_WB_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
`ifndef REGFILE_WB_ARB_FIXED_PRIO_EN
  input  logic [PW-1:0]   i_ptr,
`endif
  output logic [NREQ-1:0] o_grant
);

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    o_grant = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        o_grant    = '0;
        o_grant[j] = 1'b1;
      end
    end
  end
`else
  logic w_found;

  // Two passes: indices above the last winner first, then wrap to the rest.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && i_req[j] && (j > int'(i_ptr))) begin
        o_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!w_found && i_req[j] && (j <= int'(i_ptr))) begin
        o_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard.
// Define REGFILE_WB_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = regfile_pkg::DW,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  io_wb
);

  localparam int NR = 2**AW;
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] w_arb_grant;
  logic [NREQ-1:0] w_grant;
  logic            w_hs;
  wb_req_t         w_sel;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [NR-1:0]   r_busy;
  logic            r_conflict;

  logic [NR-1:0]   w_set_vec;
  logic [NR-1:0]   w_clr_vec;
  logic [NR-1:0]   w_busy_nxt;
  logic            w_rsv_ok;
  logic            w_conflict;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req   (io_wb.req_valid),
    .o_grant (w_arb_grant)
  );
`else
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_idx;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req   (io_wb.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant)
  );

  always_comb begin
    w_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) w_idx = PW'(j);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rr_ptr <= PW'(NREQ - 1);
    else if (w_hs) r_rr_ptr <= w_idx;
  end
`endif

  // Grants are suppressed while reset is held so nothing is acknowledged then.
  assign w_grant = rst ? '0 : w_arb_grant;
  assign w_hs    = |(w_grant & io_wb.req_valid);

  always_comb begin
    w_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        w_sel.dst  = io_wb.req_dst[j*AW +: AW];
        w_sel.data = io_wb.req_data[j*DW +: DW];
      end
    end
  end

  // Write port stage: one registered write per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_hs) begin
      r_we    <= (w_sel.dst != AW'(REG_ZERO));
      r_waddr <= w_sel.dst;
      r_wdata <= w_sel.data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign w_rsv_ok = io_wb.rsv_valid && (io_wb.rsv_reg != AW'(REG_ZERO));

  // Set after clear so a new reservation wins over the retiring write.
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (w_rsv_ok) w_set_vec[io_wb.rsv_reg] = 1'b1;
    if (r_we)     w_clr_vec[r_waddr]       = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr_vec) | w_set_vec;
    w_busy_nxt[0] = 1'b0;
  end

  assign w_conflict = w_rsv_ok && r_busy[io_wb.rsv_reg] &&
                      !(r_we && (r_waddr == io_wb.rsv_reg));

  // Scoreboard stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict;
    end
  end

  assign io_wb.req_ready    = w_grant;
  assign io_wb.rf_we        = r_we;
  assign io_wb.rf_waddr     = r_waddr;
  assign io_wb.rf_wdata     = r_wdata;
  assign io_wb.busy         = r_busy;
  assign io_wb.rsv_conflict = r_conflict;

endmodule
